// File: rtl/id_exe_reg_pkg.sv
// Shared types and constants for the ID/EXE pipeline register slice.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package id_exe_reg_pkg;

    // Default datapath and register-index widths.
    localparam int DW_DEF  = 32;
    localparam int RW_DEF  = 4;

    // Fixed-width instruction fields carried through the stage.
    localparam int CMD_W   = 4;
    localparam int SHIFT_W = 12;
    localparam int SIMM_W  = 24;
    localparam int STAT_W  = 4;

    // Position of the carry flag inside the NZCV status nibble.
    localparam int STAT_C  = 1;

    // ALU command encodings produced by decode.
    localparam logic [CMD_W-1:0] EXE_CMD_MOV = 4'b0001;
    localparam logic [CMD_W-1:0] EXE_CMD_MVN = 4'b1001;
    localparam logic [CMD_W-1:0] EXE_CMD_ADD = 4'b0010;
    localparam logic [CMD_W-1:0] EXE_CMD_ADC = 4'b0011;
    localparam logic [CMD_W-1:0] EXE_CMD_SUB = 4'b0100;
    localparam logic [CMD_W-1:0] EXE_CMD_SBC = 4'b0101;
    localparam logic [CMD_W-1:0] EXE_CMD_AND = 4'b0110;
    localparam logic [CMD_W-1:0] EXE_CMD_ORR = 4'b0111;
    localparam logic [CMD_W-1:0] EXE_CMD_EOR = 4'b1000;
    localparam logic [CMD_W-1:0] EXE_CMD_CMP = 4'b0100;
    localparam logic [CMD_W-1:0] EXE_CMD_TST = 4'b0110;
    localparam logic [CMD_W-1:0] EXE_CMD_LDR = 4'b0010;
    localparam logic [CMD_W-1:0] EXE_CMD_STR = 4'b0010;

    // Operand source select seen by EXE.
    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    // Control bundle: everything a bubble must clear.
    typedef struct packed {
        logic              valid;
        logic              wb_en;
        logic              mem_r_en;
        logic              mem_w_en;
        logic              b;
        logic              s;
        logic              imm;
        logic [CMD_W-1:0]  exe_cmd;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Source priority for one operand: MEM is the younger result, so it wins over WB.
    function automatic fwd_sel_e fwd_pick(input logic active,
                                          input logic mem_hit,
                                          input logic wb_hit);
        fwd_sel_e sel;
        sel = FWD_REG;
        if (active && mem_hit) begin
            sel = FWD_MEM;
        end else if (active && wb_hit) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/id_exe_reg_if.sv
// ID/EXE stage bundle: ID-side instruction fields, MEM/WB forwarding taps, EXE-side outputs.
// Latency: n/a (wiring only).
// Backpressure: none on the bus; stalls are expressed through freeze on the register itself.
interface id_exe_reg_if
    import id_exe_reg_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) ();

    // ID side
    logic                id_valid;
    logic [DW-1:0]       id_pc;
    logic                id_wb_en;
    logic                id_mem_r_en;
    logic                id_mem_w_en;
    logic [CMD_W-1:0]    id_exe_cmd;
    logic                id_b;
    logic                id_s;
    logic                id_imm;
    logic [SHIFT_W-1:0]  id_shift_op;
    logic [SIMM_W-1:0]   id_simm24;
    logic [RW-1:0]       id_dest;
    logic [RW-1:0]       id_src1;
    logic [RW-1:0]       id_src2;
    logic [DW-1:0]       id_val_rn;
    logic [DW-1:0]       id_val_rm;
    logic [STAT_W-1:0]   id_status;

    // Forwarding taps from later stages
    logic                mem_wb_en;
    logic [RW-1:0]       mem_dest;
    logic [DW-1:0]       mem_alu_res;
    logic                wb_wb_en;
    logic [RW-1:0]       wb_dest;
    logic [DW-1:0]       wb_value;

    // EXE side
    logic                ex_valid;
    logic                ex_wb_en;
    logic                ex_mem_r_en;
    logic                ex_mem_w_en;
    logic                ex_b;
    logic                ex_s;
    logic                ex_imm;
    logic [CMD_W-1:0]    ex_exe_cmd;
    logic [DW-1:0]       ex_pc;
    logic [SHIFT_W-1:0]  ex_shift_op;
    logic [SIMM_W-1:0]   ex_simm24;
    logic [RW-1:0]       ex_dest;
    logic                ex_c_in;
    logic [DW-1:0]       ex_op1;
    logic [DW-1:0]       ex_reg2;
    logic [1:0]          ex_sel1;
    logic [1:0]          ex_sel2;

    // Upstream/environment view: drives ID fields and taps, observes EXE.
    modport master (
        output id_valid, id_pc, id_wb_en, id_mem_r_en, id_mem_w_en, id_exe_cmd,
               id_b, id_s, id_imm, id_shift_op, id_simm24, id_dest, id_src1,
               id_src2, id_val_rn, id_val_rm, id_status,
               mem_wb_en, mem_dest, mem_alu_res, wb_wb_en, wb_dest, wb_value,
        input  ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_imm,
               ex_exe_cmd, ex_pc, ex_shift_op, ex_simm24, ex_dest, ex_c_in,
               ex_op1, ex_reg2, ex_sel1, ex_sel2
    );

    // Pipeline register view.
    modport slave (
        input  id_valid, id_pc, id_wb_en, id_mem_r_en, id_mem_w_en, id_exe_cmd,
               id_b, id_s, id_imm, id_shift_op, id_simm24, id_dest, id_src1,
               id_src2, id_val_rn, id_val_rm, id_status,
               mem_wb_en, mem_dest, mem_alu_res, wb_wb_en, wb_dest, wb_value,
        output ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_imm,
               ex_exe_cmd, ex_pc, ex_shift_op, ex_simm24, ex_dest, ex_c_in,
               ex_op1, ex_reg2, ex_sel1, ex_sel2
    );

endinterface

// File: rtl/id_exe_reg_fwd_unit.sv
// Operand forwarding for both EXE source operands: index compares against MEM/WB plus 3:1 muxes.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; re-evaluated every cycle, including while the stage is frozen.
module id_exe_reg_fwd_unit
    import id_exe_reg_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic           fwd_en,
    input  logic           ex_valid,
    input  logic [RW-1:0]  src1,
    input  logic [RW-1:0]  src2,
    input  logic [DW-1:0]  reg_rn,
    input  logic [DW-1:0]  reg_rm,
    input  logic           mem_wb_en,
    input  logic [RW-1:0]  mem_dest,
    input  logic [DW-1:0]  mem_alu_res,
    input  logic           wb_wb_en,
    input  logic [RW-1:0]  wb_dest,
    input  logic [DW-1:0]  wb_value,
    output fwd_sel_e       sel1,
    output fwd_sel_e       sel2,
    output logic [DW-1:0]  op1,
    output logic [DW-1:0]  reg2
);

    // A bubble in EXE never consumes anything, so it must not report a forward either.
    logic active;
    logic mem_hit1, mem_hit2;
    logic wb_hit1, wb_hit2;

    assign active   = fwd_en && ex_valid;
    assign mem_hit1 = mem_wb_en && (mem_dest == src1);
    assign mem_hit2 = mem_wb_en && (mem_dest == src2);
    assign wb_hit1  = wb_wb_en  && (wb_dest  == src1);
    assign wb_hit2  = wb_wb_en  && (wb_dest  == src2);

    assign sel1 = fwd_pick(active, mem_hit1, wb_hit1);
    assign sel2 = fwd_pick(active, mem_hit2, wb_hit2);

    always_comb begin
        op1 = reg_rn;
        unique case (sel1)
            FWD_MEM: op1 = mem_alu_res;
            FWD_WB:  op1 = wb_value;
            default: op1 = reg_rn;
        endcase
    end

    always_comb begin
        reg2 = reg_rm;
        unique case (sel2)
            FWD_MEM: reg2 = mem_alu_res;
            FWD_WB:  reg2 = wb_value;
            default: reg2 = reg_rm;
        endcase
    end

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with in-stage MEM/WB operand forwarding.
// Latency: 1 cycle ID to EXE for registered fields; forwarded operands are combinational on top.
// Backpressure: freeze holds every field; flush (higher priority) loads a bubble.
//
// Ports: clk, rst_n (async, active low), freeze, flush, fwd_en as plain scalars;
// bus (slave modport) carries the ID fields in, MEM/WB forwarding taps in, and EXE fields out.
module id_exe_reg
    import id_exe_reg_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         freeze,
    input  logic         flush,
    input  logic         fwd_en,
    id_exe_reg_if.slave  bus
);

    ctrl_t               ctrl_q;
    ctrl_t               id_ctrl;
    logic [DW-1:0]       pc_q;
    logic [DW-1:0]       val_rn_q;
    logic [DW-1:0]       val_rm_q;
    logic [SHIFT_W-1:0]  shift_op_q;
    logic [SIMM_W-1:0]   simm24_q;
    logic [RW-1:0]       dest_q;
    logic [RW-1:0]       src1_q;
    logic [RW-1:0]       src2_q;
    logic                c_in_q;

    fwd_sel_e            sel1;
    fwd_sel_e            sel2;
    logic [DW-1:0]       op1;
    logic [DW-1:0]       reg2;

    // Only the carry flag is needed in EXE; the other status bits stop here.
    logic                unused_status;
    assign unused_status = ^{bus.id_status[STAT_W-1:STAT_C+1], bus.id_status[STAT_C-1:0]};

    // An ID slot without a real instruction enters EXE as a bubble.
    always_comb begin
        id_ctrl = CTRL_BUBBLE;
        if (bus.id_valid) begin
            id_ctrl.valid    = 1'b1;
            id_ctrl.wb_en    = bus.id_wb_en;
            id_ctrl.mem_r_en = bus.id_mem_r_en;
            id_ctrl.mem_w_en = bus.id_mem_w_en;
            id_ctrl.b        = bus.id_b;
            id_ctrl.s        = bus.id_s;
            id_ctrl.imm      = bus.id_imm;
            id_ctrl.exe_cmd  = bus.id_exe_cmd;
        end
    end

    // Flush beats freeze: a taken branch must kill the stalled instruction too.
    // Data fields are left alone on flush; with valid=0 nothing downstream looks at them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= CTRL_BUBBLE;
            pc_q       <= '0;
            val_rn_q   <= '0;
            val_rm_q   <= '0;
            shift_op_q <= '0;
            simm24_q   <= '0;
            dest_q     <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            c_in_q     <= 1'b0;
        end else if (flush) begin
            ctrl_q     <= CTRL_BUBBLE;
        end else if (!freeze) begin
            ctrl_q     <= id_ctrl;
            pc_q       <= bus.id_pc;
            val_rn_q   <= bus.id_val_rn;
            val_rm_q   <= bus.id_val_rm;
            shift_op_q <= bus.id_shift_op;
            simm24_q   <= bus.id_simm24;
            dest_q     <= bus.id_dest;
            src1_q     <= bus.id_src1;
            src2_q     <= bus.id_src2;
            c_in_q     <= bus.id_status[STAT_C];
        end
    end

    // Forwarding runs off the registered indices every cycle, so a frozen
    // instruction keeps tracking results as they move from MEM into WB.
    id_exe_reg_fwd_unit #(
        .DW (DW),
        .RW (RW)
    ) u_fwd (
        .fwd_en      (fwd_en),
        .ex_valid    (ctrl_q.valid),
        .src1        (src1_q),
        .src2        (src2_q),
        .reg_rn      (val_rn_q),
        .reg_rm      (val_rm_q),
        .mem_wb_en   (bus.mem_wb_en),
        .mem_dest    (bus.mem_dest),
        .mem_alu_res (bus.mem_alu_res),
        .wb_wb_en    (bus.wb_wb_en),
        .wb_dest     (bus.wb_dest),
        .wb_value    (bus.wb_value),
        .sel1        (sel1),
        .sel2        (sel2),
        .op1         (op1),
        .reg2        (reg2)
    );

    assign bus.ex_valid    = ctrl_q.valid;
    assign bus.ex_wb_en    = ctrl_q.wb_en;
    assign bus.ex_mem_r_en = ctrl_q.mem_r_en;
    assign bus.ex_mem_w_en = ctrl_q.mem_w_en;
    assign bus.ex_b        = ctrl_q.b;
    assign bus.ex_s        = ctrl_q.s;
    assign bus.ex_imm      = ctrl_q.imm;
    assign bus.ex_exe_cmd  = ctrl_q.exe_cmd;
    assign bus.ex_pc       = pc_q;
    assign bus.ex_shift_op = shift_op_q;
    assign bus.ex_simm24   = simm24_q;
    assign bus.ex_dest     = dest_q;
    assign bus.ex_c_in     = c_in_q;
    assign bus.ex_op1      = op1;
    assign bus.ex_reg2     = reg2;
    assign bus.ex_sel1     = sel1;
    assign bus.ex_sel2     = sel2;

endmodule
